program_sequencer_stack: RTL and testbench
==========================================

# program_sequencer_stack

Parametrised next-generation program sequencer for the course microprocessor. Generates the program-memory address each cycle, executes unconditional and conditional jumps, and adds subroutine call/return through a hardware return-address stack. It sits between the instruction decoder (jump/call/return strobes, jump target) and the synchronous program memory (combinational `pm_addr`).

## Interface
- `PC_W`, 8: width of the program counter, jump target and stack entries.
- `STACK_DEPTH`, 4: number of return-address entries; must be ≥ 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `hold`  in  1  stall; freezes PC and stack.
- `jmp`  in  1  unconditional jump to `jmp_addr`.
- `jmp_nz`  in  1  conditional jump; taken only when `dont_jmp` = 0.
- `dont_jmp`  in  1  ALU zero flag (1 = result was zero).
- `call`  in  1  push the return address and jump to `jmp_addr`.
- `ret`  in  1  pop the return address and jump to it.
- `clr_err`  in  1  synchronous clear of the sticky error flags.
- `jmp_addr`  in  PC_W  jump/call target.
- `pc`  out  PC_W  registered address of the instruction currently executing.
- `pm_addr`  out  PC_W  combinational next address, driven to program memory.
- `sp`  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- `stack_full`, `stack_empty`  out  1  sp == STACK_DEPTH / sp == 0.
- `ovf_err`, `unf_err`  out  1  sticky overflow/underflow flags.

## Operation
- `pm_addr` is selected by priority (first match wins):
  - `!reset_n`: 0.
  - `hold`: `pc`.
  - `ret`: top of stack, or `pc+1` when empty.
  - `call`: `jmp_addr`.
  - `jmp`: `jmp_addr`.
  - `jmp_nz && !dont_jmp`: `jmp_addr`.
  - Otherwise: `pc+1`.
- Lower-priority strobes asserted alongside a winning strobe are ignored entirely.
- `pc+1` wraps modulo 2^PC_W (for example 8'hFF -> 8'h00). Stored return addresses wrap the same way.
- Call, stack not full: push `pc+1` at index `sp`; `sp` increments.
- Call, stack full: the jump is still taken; the push is discarded and `sp` is unchanged; `ovf_err` sets.
- Ret, stack not empty: pop entry `sp-1`; `sp` decrements.
- Ret, stack empty: behaves as a plain `pc+1` advance; `unf_err` sets.
- `hold` overrides all strobes: no push, no pop, no flag update.
- `clr_err` clears both flags on the next edge. A new error event in the same cycle wins, so its flag stays or becomes set.
- Stack storage is not reset; only `sp` is reset. Entries at or above `sp` are don't-care.

## Timing
- `pc <= pm_addr` on every rising edge. `pm_addr` is purely combinational from the inputs, `pc`, `sp` and the stack, with zero latency.
- Program memory registers `pm_addr`, so the instruction at `pm_addr` reaches the decoder in the cycle its address sits in `pc`.
- A jump, call or return issued in cycle N yields `pc` = target in cycle N+1; there are no delay slots.
- Reset values: `pc` = 0, `pm_addr` = 0, `sp` = 0, `stack_empty` = 1, `stack_full` = 0, `ovf_err` = 0, `unf_err` = 0.
- Reset asserted mid-call or mid-return aborts the operation immediately and asynchronously. After release, the first edge loads `pc` = `pm_addr` = 0+1 (normal advance) unless strobes say otherwise.
- `stack_full`, `stack_empty` and `sp` reflect the registered state and change one edge after a push or pop.

## Test plan
- Reset then free-run with PC_W=8: `pc` steps 0,1,2,…; at 8'hFF the next value is 8'h00; `pm_addr` always equals `pc+1`.
- `jmp`=1, `jmp_addr`=8'h40 at `pc`=5 -> `pc`=8'h40 next cycle. `jmp_nz` with `dont_jmp`=1 -> `pc`=6. `jmp_nz` with `dont_jmp`=0 -> `pc`=8'h40.
- Nested calls at `pc`=3 (to 8'h20), 8'h20 (to 8'h30), 8'h30 (to 8'h50), then three `ret` -> `pc` sequence 8'h31, 8'h21, 4; `sp` goes 1,2,3,2,1,0.
- With STACK_DEPTH=4, five consecutive calls -> fifth jump taken, `sp` stays 4, `ovf_err`=1. `ret` on empty at `pc`=9 -> `pc`=10, `unf_err`=1. `clr_err` clears both.
- `hold`=1 together with `call` for 3 cycles -> `pc`, `sp` and flags unchanged; on release the call executes once.
- `call` and `ret` together with a non-empty stack (top 8'h11) -> `pc`=8'h11, `sp` decrements. `reset_n` pulsed low mid-sequence -> `pc`=0 and `sp`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/program_sequencer_stack.sv
// Program sequencer: chooses the next program-memory address each cycle and keeps
// a hardware return-address stack so the decoder can issue subroutine call/return.
module program_sequencer_stack #(
   parameter int PC_W        = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               hold,
   input  logic                               jmp,
   input  logic                               jmp_nz,
   input  logic                               dont_jmp,
   input  logic                               call,
   input  logic                               ret,
   input  logic                               clr_err,
   input  logic [PC_W-1:0]                    jmp_addr,
   output logic [PC_W-1:0]                    pc,
   output logic [PC_W-1:0]                    pm_addr,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
   output logic                               stack_full,
   output logic                               stack_empty,
   output logic                               ovf_err,
   output logic                               unf_err
);

   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [PC_W-1:0]  r_pc;
   logic [SP_W-1:0]  r_sp;
   logic             r_ovf_err;
   logic             r_unf_err;
   logic [PC_W-1:0]  r_stack [STACK_DEPTH];

   logic [PC_W-1:0]  w_pc_inc;
   logic [PC_W-1:0]  w_tos;
   logic [PC_W-1:0]  w_pm_addr;
   logic [IDX_W-1:0] w_top_idx;
   logic [IDX_W-1:0] w_wr_idx;
   logic             w_empty;
   logic             w_full;
   logic             w_ret_act;
   logic             w_ret_pop;
   logic             w_ret_unf;
   logic             w_call_act;
   logic             w_push;
   logic             w_call_ovf;
   logic             w_jmp_take;

   assign w_pc_inc  = r_pc + PC_W'(1);
   assign w_empty   = (r_sp == SP_W'(0));
   assign w_full    = (r_sp == SP_W'(STACK_DEPTH));
   // Top-of-stack index is only meaningful when the stack is non-empty.
   assign w_top_idx = IDX_W'(r_sp - SP_W'(1));
   assign w_wr_idx  = IDX_W'(r_sp);
   assign w_tos     = r_stack[w_top_idx];

   // Strobe decode in priority order: hold > ret > call > jmp > jmp_nz.
   assign w_ret_act  = ret & ~hold;
   assign w_ret_pop  = w_ret_act & ~w_empty;
   assign w_ret_unf  = w_ret_act & w_empty;
   assign w_call_act = call & ~ret & ~hold;
   assign w_push     = w_call_act & ~w_full & reset_n;
   assign w_call_ovf = w_call_act & w_full;
   assign w_jmp_take = ~hold & ~ret & ~call & (jmp | (jmp_nz & ~dont_jmp));

   always_comb begin
      w_pm_addr = w_pc_inc;
      if (!reset_n)
         w_pm_addr = '0;
      else if (hold)
         w_pm_addr = r_pc;
      else if (w_ret_pop)
         w_pm_addr = w_tos;
      else if (w_call_act || w_jmp_take)
         w_pm_addr = jmp_addr;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc      <= '0;
         r_sp      <= '0;
         r_ovf_err <= 1'b0;
         r_unf_err <= 1'b0;
      end else begin
         r_pc <= w_pm_addr;
         if (w_push)
            r_sp <= r_sp + SP_W'(1);
         else if (w_ret_pop)
            r_sp <= r_sp - SP_W'(1);
         // A fresh error in the same cycle as clr_err keeps its flag set.
         if (!hold) begin
            r_ovf_err <= (r_ovf_err & ~clr_err) | w_call_ovf;
            r_unf_err <= (r_unf_err & ~clr_err) | w_ret_unf;
         end
      end
   end

   // Return-address storage is deliberately left unreset; only sp qualifies it.
   for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      always_ff @(posedge clk) begin
         if (w_push && (w_wr_idx == IDX_W'(gi)))
            r_stack[gi] <= w_pc_inc;
      end
   end

   assign pc          = r_pc;
   assign pm_addr     = w_pm_addr;
   assign sp          = r_sp;
   assign stack_full  = w_full;
   assign stack_empty = w_empty;
   assign ovf_err     = r_ovf_err;
   assign unf_err     = r_unf_err;

endmodule

// File: tb/tb_program_sequencer_stack.sv
// Directed bench for program_sequencer_stack (PC_W=8, STACK_DEPTH=4).
module tb_program_sequencer_stack;

   logic       clk;
   logic       reset_n;
   logic       hold, jmp, jmp_nz, dont_jmp, call, ret, clr_err;
   logic [7:0] jmp_addr;
   logic [7:0] pc, pm_addr;
   logic [2:0] sp;
   logic       stack_full, stack_empty, ovf_err, unf_err;

   int n_checks = 0;
   int n_fail   = 0;

   program_sequencer_stack #(.PC_W(8), .STACK_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .hold(hold), .jmp(jmp), .jmp_nz(jmp_nz),
      .dont_jmp(dont_jmp), .call(call), .ret(ret), .clr_err(clr_err),
      .jmp_addr(jmp_addr), .pc(pc), .pm_addr(pm_addr), .sp(sp),
      .stack_full(stack_full), .stack_empty(stack_empty),
      .ovf_err(ovf_err), .unf_err(unf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hold = 0; jmp = 0; jmp_nz = 0; dont_jmp = 0; call = 0; ret = 0; clr_err = 0;
      jmp_addr = 8'h00;
   endtask

   task automatic goto(input logic [7:0] a);
      idle(); jmp = 1; jmp_addr = a;
      tick();
      idle();
   endtask

   task automatic test_reset();
      idle();
      reset_n = 0;
      #2;
      n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 8'h00); end
      n_checks++; if (pm_addr !== 8'h00) begin n_fail++; $display("FAIL reset_pm_addr: got %h expected %h", pm_addr, 8'h00); end
      n_checks++; if (sp !== 3'd0) begin n_fail++; $display("FAIL reset_sp: got %0d expected 0", sp); end
      n_checks++; if ({stack_empty, stack_full, ovf_err, unf_err} !== 4'b1000) begin n_fail++; $display("FAIL reset_flags: got %b expected 1000", {stack_empty, stack_full, ovf_err, unf_err}); end
      tick(); tick();
      n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_hold_pc: got %h expected %h", pc, 8'h00); end
      reset_n = 1;
      #1;
      n_checks++; if (pm_addr !== 8'h01) begin n_fail++; $display("FAIL release_pm_addr: got %h expected %h", pm_addr, 8'h01); end
      tick();
      n_checks++; if (pc !== 8'h01) begin n_fail++; $display("FAIL release_pc: got %h expected %h", pc, 8'h01); end
      $display("test_reset done");
   endtask

   task automatic test_free_run();
      logic [7:0] exp_pc;
      exp_pc = 8'h01;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (pm_addr !== exp_pc + 8'h01) begin n_fail++; $display("FAIL run_pm_addr: got %h expected %h", pm_addr, exp_pc + 8'h01); end
         tick();
         exp_pc = exp_pc + 8'h01;
         n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL run_pc: got %h expected %h", pc, exp_pc); end
      end
      goto(8'hFD);
      exp_pc = 8'hFD;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_pc = exp_pc + 8'h01;
         n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL wrap_pc: got %h expected %h", pc, exp_pc); end
      end
      $display("test_free_run done, pc=%h", pc);
   endtask

   task automatic test_jumps();
      goto(8'h05);
      jmp = 1; jmp_addr = 8'h40;
      #1;
      n_checks++; if (pm_addr !== 8'h40) begin n_fail++; $display("FAIL jmp_pm_addr: got %h expected %h", pm_addr, 8'h40); end
      tick(); idle();
      n_checks++; if (pc !== 8'h40) begin n_fail++; $display("FAIL jmp_pc: got %h expected %h", pc, 8'h40); end
      goto(8'h05);
      jmp_nz = 1; dont_jmp = 1; jmp_addr = 8'h40;
      tick(); idle();
      n_checks++; if (pc !== 8'h06) begin n_fail++; $display("FAIL jnz_not_taken: got %h expected %h", pc, 8'h06); end
      jmp_nz = 1; dont_jmp = 0; jmp_addr = 8'h40;
      tick(); idle();
      n_checks++; if (pc !== 8'h40) begin n_fail++; $display("FAIL jnz_taken: got %h expected %h", pc, 8'h40); end
      $display("test_jumps done");
   endtask

   task automatic test_nested_calls();
      logic [7:0] tgt [3];
      logic [7:0] ret_pc [3];
      tgt[0] = 8'h20; tgt[1] = 8'h30; tgt[2] = 8'h50;
      ret_pc[0] = 8'h31; ret_pc[1] = 8'h21; ret_pc[2] = 8'h04;
      goto(8'h03);
      for (int i = 0; i < 3; i++) begin
         call = 1; jmp_addr = tgt[i];
         tick(); idle();
         n_checks++; if (pc !== tgt[i]) begin n_fail++; $display("FAIL call_pc[%0d]: got %h expected %h", i, pc, tgt[i]); end
         n_checks++; if (sp !== 3'(i + 1)) begin n_fail++; $display("FAIL call_sp[%0d]: got %0d expected %0d", i, sp, i + 1); end
      end
      for (int i = 0; i < 3; i++) begin
         ret = 1;
         tick(); idle();
         n_checks++; if (pc !== ret_pc[i]) begin n_fail++; $display("FAIL ret_pc[%0d]: got %h expected %h", i, pc, ret_pc[i]); end
         n_checks++; if (sp !== 3'(2 - i)) begin n_fail++; $display("FAIL ret_sp[%0d]: got %0d expected %0d", i, sp, 2 - i); end
      end
      $display("test_nested_calls done");
   endtask

   task automatic test_overflow_underflow();
      logic [7:0] pops [4];
      pops[0] = 8'h63; pops[1] = 8'h62; pops[2] = 8'h61; pops[3] = 8'h05;
      goto(8'h04);
      for (int i = 0; i < 5; i++) begin
         call = 1; jmp_addr = 8'h60 + 8'(i);
         tick(); idle();
         n_checks++; if (pc !== 8'h60 + 8'(i)) begin n_fail++; $display("FAIL ovf_call_pc[%0d]: got %h expected %h", i, pc, 8'h60 + 8'(i)); end
         if (i == 3) begin
            n_checks++; if (stack_full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b expected 1", stack_full); end
            n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", ovf_err); end
         end
      end
      n_checks++; if (sp !== 3'd4) begin n_fail++; $display("FAIL ovf_sp: got %0d expected 4", sp); end
      n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", ovf_err); end
      for (int i = 0; i < 4; i++) begin
         ret = 1;
         tick(); idle();
         n_checks++; if (pc !== pops[i]) begin n_fail++; $display("FAIL ovf_pop[%0d]: got %h expected %h", i, pc, pops[i]); end
      end
      n_checks++; if (stack_empty !== 1'b1) begin n_fail++; $display("FAIL empty_flag: got %b expected 1", stack_empty); end
      goto(8'h09);
      ret = 1;
      tick(); idle();
      n_checks++; if (pc !== 8'h0A) begin n_fail++; $display("FAIL unf_pc: got %h expected %h", pc, 8'h0A); end
      n_checks++; if ({sp, unf_err, ovf_err} !== 5'b000_1_1) begin n_fail++; $display("FAIL unf_state: got sp=%0d unf=%b ovf=%b expected sp=0 unf=1 ovf=1", sp, unf_err, ovf_err); end
      clr_err = 1; ret = 1;
      tick(); idle();
      n_checks++; if ({unf_err, ovf_err} !== 2'b10) begin n_fail++; $display("FAIL clr_vs_new: got unf=%b ovf=%b expected unf=1 ovf=0", unf_err, ovf_err); end
      clr_err = 1;
      tick(); idle();
      n_checks++; if ({unf_err, ovf_err} !== 2'b00) begin n_fail++; $display("FAIL clr_err: got unf=%b ovf=%b expected 00", unf_err, ovf_err); end
      $display("test_overflow_underflow done");
   endtask

   task automatic test_hold_call_ret();
      goto(8'h10);
      hold = 1; call = 1; jmp_addr = 8'h70;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (pm_addr !== 8'h10) begin n_fail++; $display("FAIL hold_pm_addr[%0d]: got %h expected %h", i, pm_addr, 8'h10); end
         tick();
         n_checks++; if ({pc, sp, ovf_err} !== {8'h10, 3'd0, 1'b0}) begin n_fail++; $display("FAIL hold_state[%0d]: got pc=%h sp=%0d expected pc=10 sp=0", i, pc, sp); end
      end
      hold = 0;
      tick(); idle();
      n_checks++; if ({pc, sp} !== {8'h70, 3'd1}) begin n_fail++; $display("FAIL hold_release: got pc=%h sp=%0d expected pc=70 sp=1", pc, sp); end
      tick();
      n_checks++; if ({pc, sp} !== {8'h71, 3'd1}) begin n_fail++; $display("FAIL call_once: got pc=%h sp=%0d expected pc=71 sp=1", pc, sp); end
      call = 1; ret = 1; jmp_addr = 8'h99;
      #1;
      n_checks++; if (pm_addr !== 8'h11) begin n_fail++; $display("FAIL callret_pm_addr: got %h expected %h", pm_addr, 8'h11); end
      tick(); idle();
      n_checks++; if ({pc, sp} !== {8'h11, 3'd0}) begin n_fail++; $display("FAIL callret_state: got pc=%h sp=%0d expected pc=11 sp=0", pc, sp); end
      $display("test_hold_call_ret done");
   endtask

   task automatic test_async_reset();
      goto(8'h12);
      call = 1; jmp_addr = 8'h80;
      tick();
      n_checks++; if ({pc, sp} !== {8'h80, 3'd1}) begin n_fail++; $display("FAIL pre_reset: got pc=%h sp=%0d expected pc=80 sp=1", pc, sp); end
      #2;
      reset_n = 0;
      #1;
      n_checks++; if ({pc, sp, pm_addr} !== {8'h00, 3'd0, 8'h00}) begin n_fail++; $display("FAIL async_reset: got pc=%h sp=%0d pm=%h expected 00/0/00", pc, sp, pm_addr); end
      idle();
      tick();
      reset_n = 1;
      #1;
      tick();
      n_checks++; if ({pc, sp} !== {8'h01, 3'd0}) begin n_fail++; $display("FAIL post_reset: got pc=%h sp=%0d expected pc=01 sp=0", pc, sp); end
      $display("test_async_reset done");
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_jumps();
      test_nested_calls();
      test_overflow_underflow();
      test_hold_call_ret();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
